// File: rtl/fb_arbiter.sv
// fb_arbiter: shares a single-port framebuffer RAM between 2x2-doubled VGA scanout and a buffered pixel-write stream
module fb_arbiter #(
    parameter int FB_W       = 320,
    parameter int FB_H       = 240,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              blank_b_in,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              blank_b_out,
    output logic              wr_oob
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_W * FB_H);

    typedef enum logic [1:0] {IDLE, DISP, WRITE} slot_t;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PW:0]       wptr, rptr;
    logic              full, empty, push, pop, head_ok;
    logic [ADDR_W-1:0] disp_addr, head_addr;
    logic [DATA_W-1:0] head_data, pix;
    logic [1:0]        disp_d;
    logic [2:0]        hs_d, vs_d, bl_d;
    slot_t             slot;
    logic              unused_ok;

    assign unused_ok = y[0];
    assign empty     = wptr == rptr;
    assign full      = wptr == (rptr ^ {1'b1, {PW{1'b0}}});
    assign wr_ready  = !full;
    assign push      = wr_valid && !full;
    assign head_addr = fifo_addr[rptr[PW-1:0]];
    assign head_data = fifo_data[rptr[PW-1:0]];
    assign head_ok   = head_addr < FB_SIZE;
    assign disp_addr = ADDR_W'(y[9:1]) * ADDR_W'(FB_W) + ADDR_W'(x[9:1]);

    // scanout owns even active pixels; odd pixels and blanking drain the FIFO
    always_comb begin
        slot = (blank_b_in && !x[0]) ? DISP : (!empty ? WRITE : IDLE);
        pop  = slot == WRITE;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wptr[PW-1:0]] <= wr_addr;
            fifo_data[wptr[PW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wptr      <= '0;
            rptr      <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            wr_oob    <= 1'b0;
            disp_d    <= '0;
            pix       <= '0;
            hs_d      <= '1;
            vs_d      <= '1;
            bl_d      <= '0;
        end else begin
            wptr   <= push ? wptr + 1'b1 : wptr;
            rptr   <= pop ? rptr + 1'b1 : rptr;
            ram_we <= pop && head_ok;
            if (slot == DISP)
                ram_addr <= disp_addr;
            else if (pop && head_ok) begin
                ram_addr  <= head_addr;
                ram_wdata <= head_data;
            end
            if (pop && !head_ok)
                wr_oob <= 1'b1;
            // read data arrives one cycle after the address, so capture two edges after the decision
            disp_d <= {disp_d[0], slot == DISP};
            if (disp_d[1])
                pix <= ram_rdata;
            hs_d <= {hs_d[1:0], hsync_in};
            vs_d <= {vs_d[1:0], vsync_in};
            bl_d <= {bl_d[1:0], blank_b_in};
        end
    end

    assign hsync_out   = hs_d[2];
    assign vsync_out   = vs_d[2];
    assign blank_b_out = bl_d[2];
    assign pix_data    = blank_b_out ? pix : '0;
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: random VGA-timed scanout plus random writer, checked against a queue-based reference model
module tb_fb_arbiter;
    localparam int NPIX = 76800;

    logic        clk = 0, reset_b = 0;
    logic [9:0]  x = 0, y = 0;
    logic        hsync_in = 1, vsync_in = 1, blank_b_in = 0;
    logic        wr_valid = 0, wr_ready;
    logic [16:0] wr_addr = 0;
    logic [7:0]  wr_data = 0;
    logic [16:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata, ram_rdata = 0, pix_data;
    logic        hsync_out, vsync_out, blank_b_out, wr_oob;

    fb_arbiter dut (
        .clk(clk), .reset_b(reset_b), .x(x), .y(y),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_b_in(blank_b_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .pix_data(pix_data), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .blank_b_out(blank_b_out), .wr_oob(wr_oob)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [NPIX];
    logic [7:0] ref_mem [NPIX];

    always @(posedge clk) begin
        if (ram_we && ram_addr < NPIX) mem[ram_addr] <= ram_wdata;
        ram_rdata <= (ram_addr < NPIX) ? mem[ram_addr] : 8'h0;
    end

    typedef struct {int a; logic [7:0] d;} wr_t;
    wr_t q[$];
    int   m_addr, pend_a, tx, ty, dir_idx, wmode;
    logic [7:0] m_wd, m_pix, pv0, pv1, pend_d;
    logic m_we, m_oob, pd0, pd1, pend, m_acc, oob_en, jump_en;
    logic [2:0] m_hs, m_vs, m_bl;
    int vectors = 0, errors = 0;

    // reference: reads see every write decided earlier; writes commit one edge after the decision
    always @(posedge clk) begin
        if (!reset_b) begin
            q.delete();
            m_addr = 0; m_we = 0; m_wd = 0; m_oob = 0; m_pix = 0;
            pd0 = 0; pd1 = 0; pend = 0; m_acc = 0;
            m_hs = 3'b111; m_vs = 3'b111; m_bl = 3'b000;
        end else begin
            logic rdy, disp;
            wr_t e;
            if (pend) ref_mem[pend_a] = pend_d;
            pend = 0;
            rdy = q.size() < 4;
            disp = blank_b_in && !x[0];
            if (pd1) m_pix = pv1;
            pd1 = pd0; pv1 = pv0; pd0 = disp;
            if (disp) begin
                m_addr = (int'(y) / 2) * 320 + int'(x) / 2;
                pv0 = ref_mem[m_addr];
                m_we = 0;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                if (e.a < NPIX) begin
                    m_we = 1; m_addr = e.a; m_wd = e.d;
                    pend = 1; pend_a = e.a; pend_d = e.d;
                end else begin
                    m_we = 0; m_oob = 1;
                end
            end else m_we = 0;
            m_acc = wr_valid && rdy;
            if (m_acc) q.push_back('{int'(wr_addr), wr_data});
            m_hs = {m_hs[1:0], hsync_in};
            m_vs = {m_vs[1:0], vsync_in};
            m_bl = {m_bl[1:0], blank_b_in};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset();
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_wdata", 32'(ram_wdata), 0);
        chk("rst_pix", 32'(pix_data), 0);
        chk("rst_sync", {29'd0, hsync_out, vsync_out, blank_b_out}, 32'b110);
        chk("rst_oob", 32'(wr_oob), 0);
    endtask

    task automatic drive();
        tx++;
        if (tx == 800) begin
            tx = 0;
            ty = (ty == 524) ? 0 : ty + 1;
            if (jump_en && $urandom_range(0, 3) == 0) ty = $urandom_range(0, 524);
        end
        x = 10'(tx);
        y = 10'(ty);
        hsync_in   = !(tx >= 656 && tx < 752);
        vsync_in   = !(ty == 490 || ty == 491);
        blank_b_in = tx < 640 && ty < 480;
        if (wmode == 1) begin
            if (m_acc) dir_idx++;
            wr_valid = dir_idx < 8;
            wr_addr  = 17'(dir_idx);
            wr_data  = 8'(dir_idx * 17 + 5);
        end else if (wmode == 2) begin
            wr_valid = 0;
        end else begin
            wr_valid = $urandom_range(0, 3) != 0;
            wr_data  = 8'($urandom);
            if (oob_en && $urandom_range(0, 15) == 0)
                wr_addr = 17'(NPIX + $urandom_range(0, 1000));
            else if ($urandom_range(0, 1) == 0)
                wr_addr = 17'($urandom_range(0, NPIX - 1));
            else
                wr_addr = 17'((ty % 480) / 2 * 320 + $urandom_range(0, 319));
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (reset_b) begin
            chk("ram_addr", 32'(ram_addr), 32'(m_addr));
            chk("ram_we", 32'(ram_we), 32'(m_we));
            chk("ram_wdata", 32'(ram_wdata), 32'(m_wd));
            chk("pix_data", 32'(pix_data), 32'(m_bl[2] ? m_pix : 8'h0));
            chk("sync", {29'd0, hsync_out, vsync_out, blank_b_out}, {29'd0, m_hs[2], m_vs[2], m_bl[2]});
            chk("wr_ready", 32'(wr_ready), 32'(q.size() < 4));
            chk("wr_oob", 32'(wr_oob), 32'(m_oob));
        end
        drive();
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        tx = 797; ty = 1; wmode = 0; oob_en = 0; jump_en = 0; dir_idx = 0;
        repeat (3) @(negedge clk);
        chk_reset();
        reset_b = 1;
        repeat (2400) step();
        jump_en = 1;
        repeat (1600) step();
        jump_en = 0;
        tx = 599; ty = 523; wmode = 1; dir_idx = 0;
        repeat (200) step();
        chk("dir_accepted", 32'(dir_idx), 8);
        wmode = 2;
        repeat (1800) step();
        wmode = 0; oob_en = 1;
        repeat (1600) step();
        chk("oob_seen", 32'(wr_oob), 1);
        #1 reset_b = 0;
        #1 chk_reset();
        repeat (3) step();
        reset_b = 1;
        oob_en = 0; jump_en = 1;
        repeat (1600) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
